clock_mode_ctrl: RTL and testbench

- Front-panel controller for the digital clock. It owns the mode FSM for run, time-set and alarm-set, and turns three push-buttons into edit values and one-cycle load strobes.
- The load strobes drive the hour, minute and alarm registers.
- It also decides when the alarm rings.
- Sits between the key inputs and the hour/minute counters and alarm registers; runs on the system clock, paced by the 1 Hz tick from the divider.

---
 rtl/clock_mode_ctrl.sv | 175 +++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the digital clock: run/time-set/alarm-set mode FSM,
// key synchronisation, edit value and load strobes, and alarm ring control.
module clock_mode_ctrl #(
   parameter int unsigned RING_SECS   = 30,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1s,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_ok,
   input  logic       alarm_en,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] alm_hour,
   input  logic [5:0] alm_min,
   output logic [5:0] set_x,
   output logic       hour_set,
   output logic       min_set,
   output logic [2:0] alarm_set,
   output logic [2:0] mode,
   output logic       blink,
   output logic       ring
);
   localparam int unsigned VW      = 6;
   localparam int unsigned CW      = 6;
   localparam int unsigned KN      = 3;
   localparam int unsigned EV_MODE = 0;
   localparam int unsigned EV_INC  = 1;
   localparam int unsigned EV_OK   = 2;
   localparam logic [VW-1:0] HOUR_MAX = VW'(23);
   localparam logic [VW-1:0] MIN_MAX  = VW'(59);

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      SET_H = 3'd1,
      SET_M = 3'd2,
      ALM_H = 3'd3,
      ALM_M = 3'd4
   } state_t;

   state_t                          state, state_nx;
   logic [SYNC_STAGES-1:0][KN-1:0]  sync_q;
   logic [KN-1:0]                   key_prev;
   logic [KN-1:0]                   key_evt_c;
   logic [VW-1:0]                   edit_val, edit_nx, set_x_nx;
   logic [CW-1:0]                   ring_cnt, cnt_nx;
   logic                            fired, fired_nx, ring_nx, blink_nx;
   logic                            hour_set_nx, min_set_nx, alm_stb_nx, inc_hit;
   logic [1:0]                      alm_fld_nx;
   logic [2:0]                      alarm_set_nx;
   logic                            trigger_c;

   // Key synchroniser chain and rising-edge detect; bit order {ok, inc, mode}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         key_prev <= '0;
      end else begin
         if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], {key_ok, key_inc, key_mode}};
         else                 sync_q <= {key_ok, key_inc, key_mode};
         key_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign key_evt_c = sync_q[SYNC_STAGES-1] & ~key_prev;

   assign trigger_c = tick_1s && alarm_en && !fired &&
                      (state inside {RUN, SET_H, SET_M}) &&
                      (cur_hour == alm_hour) && (cur_min == alm_min);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         edit_val  <= '0;
         set_x     <= '0;
         hour_set  <= 1'b0;
         min_set   <= 1'b0;
         alarm_set <= '0;
         blink     <= 1'b0;
         ring      <= 1'b0;
         fired     <= 1'b0;
         ring_cnt  <= '0;
      end else begin
         state     <= state_nx;
         edit_val  <= edit_nx;
         set_x     <= set_x_nx;
         hour_set  <= hour_set_nx;
         min_set   <= min_set_nx;
         alarm_set <= alarm_set_nx;
         blink     <= blink_nx;
         ring      <= ring_nx;
         fired     <= fired_nx;
         ring_cnt  <= cnt_nx;
      end
   end

   assign mode = 3'(state);

   always_comb begin
      state_nx     = state;
      edit_nx      = edit_val;
      hour_set_nx  = 1'b0;
      min_set_nx   = 1'b0;
      alm_stb_nx   = 1'b0;
      alm_fld_nx   = 2'b00;
      inc_hit      = 1'b0;
      blink_nx     = blink;
      ring_nx      = ring;
      fired_nx     = fired;
      cnt_nx       = ring_cnt;
      alarm_set_nx = 3'b000;

      // Event arbitration: mode over ok over inc; losers are dropped
      if (!(state inside {RUN, SET_H, SET_M, ALM_H, ALM_M})) begin
         state_nx = RUN;
      end else if (key_evt_c[EV_MODE]) begin
         case (state)
            RUN:     begin state_nx = SET_H; edit_nx = cur_hour; end
            SET_H:   begin state_nx = SET_M; edit_nx = cur_min;  end
            SET_M:   begin state_nx = ALM_H; edit_nx = alm_hour; end
            ALM_H:   begin state_nx = ALM_M; edit_nx = alm_min;  end
            default: state_nx = RUN;
         endcase
      end else if (key_evt_c[EV_OK]) begin
         case (state)
            SET_H:   begin hour_set_nx = 1'b1; state_nx = SET_M; edit_nx = cur_min; end
            SET_M:   begin min_set_nx = 1'b1; state_nx = RUN; end
            ALM_H:   begin
               alm_stb_nx = 1'b1; alm_fld_nx = 2'b01; state_nx = ALM_M; edit_nx = alm_min;
            end
            ALM_M:   begin alm_stb_nx = 1'b1; alm_fld_nx = 2'b10; state_nx = RUN; end
            default: state_nx = RUN;
         endcase
      end else if (key_evt_c[EV_INC]) begin
         case (state)
            SET_H, ALM_H: begin
               inc_hit = 1'b1;
               edit_nx = (edit_val >= HOUR_MAX) ? '0 : edit_val + VW'(1);
            end
            SET_M, ALM_M: begin
               inc_hit = 1'b1;
               edit_nx = (edit_val >= MIN_MAX) ? '0 : edit_val + VW'(1);
            end
            default: state_nx = RUN;
         endcase
      end

      // Strobe cycle keeps the value being loaded on set_x
      set_x_nx = (hour_set_nx || min_set_nx || alm_stb_nx) ? edit_val : edit_nx;

      if (alm_stb_nx)          alarm_set_nx = {1'b1, alm_fld_nx};
      else if (state_nx == ALM_H) alarm_set_nx = 3'b001;
      else if (state_nx == ALM_M) alarm_set_nx = 3'b010;

      if ((state_nx != state) || inc_hit) blink_nx = 1'b0;
      else if (state == RUN)              blink_nx = 1'b0;
      else if (tick_1s)                   blink_nx = ~blink;

      // Ring countdown, silence on any key or enable drop, re-arm on minute change
      if (ring) begin
         if (ring_cnt == '0) ring_nx = 1'b0;
         else if (tick_1s)   cnt_nx  = ring_cnt - CW'(1);
      end
      if ((|key_evt_c) || !alarm_en) ring_nx = 1'b0;
      if (cur_min != alm_min)        fired_nx = 1'b0;
      if (trigger_c) begin
         ring_nx  = 1'b1;
         fired_nx = 1'b1;
         cnt_nx   = CW'(RING_SECS);
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random keys/ticks, compared
// every cycle against an integer-level reference model of the panel behaviour.
module tb_clock_mode_ctrl;
   localparam int unsigned RS = 3;
   localparam int unsigned SS = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1s = 1'b0;
   logic       key_mode = 1'b0, key_inc = 1'b0, key_ok = 1'b0;
   logic       alarm_en = 1'b0;
   logic [5:0] cur_hour = 6'd12, cur_min = 6'd0, alm_hour = 6'd0, alm_min = 6'd0;
   logic [5:0] set_x;
   logic       hour_set, min_set, blink, ring;
   logic [2:0] alarm_set, mode;

   clock_mode_ctrl #(.RING_SECS(RS), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s),
      .key_mode(key_mode), .key_inc(key_inc), .key_ok(key_ok), .alarm_en(alarm_en),
      .cur_hour(cur_hour), .cur_min(cur_min), .alm_hour(alm_hour), .alm_min(alm_min),
      .set_x(set_x), .hour_set(hour_set), .min_set(min_set), .alarm_set(alarm_set),
      .mode(mode), .blink(blink), .ring(ring)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: state index 0..4 walks RUN,SET_H,SET_M,ALM_H,ALM_M
   int       m_st = 0, m_ev = 0, m_setx = 0, m_cnt = 0;
   bit       m_blink = 0, m_ring = 0, m_fired = 0, m_hs = 0, m_ms = 0;
   bit [2:0] m_as = 0;
   bit [2:0] hist [0:SS];

   task automatic model_reset();
      m_st = 0; m_ev = 0; m_setx = 0; m_cnt = 0;
      m_blink = 0; m_ring = 0; m_fired = 0; m_hs = 0; m_ms = 0; m_as = 0;
      for (int j = 0; j <= SS; j++) hist[j] = 3'b000;
   endtask

   function automatic int load_for(input int st);
      case (st)
         1: return int'(cur_hour);
         2: return int'(cur_min);
         3: return int'(alm_hour);
         4: return int'(alm_min);
         default: return m_ev;
      endcase
   endfunction

   task automatic model_step();
      bit [2:0] ev;
      int  old_st, old_ev, lim;
      bit  astb, inc_done, r, f;
      bit [1:0] fld;
      int  c;
      ev = hist[SS-1] & ~hist[SS];
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {key_ok, key_inc, key_mode};
      old_st = m_st; old_ev = m_ev;
      m_hs = 0; m_ms = 0; astb = 0; fld = 0; inc_done = 0;
      if (ev[0]) begin
         m_st = (m_st + 1) % 5;
         m_ev = load_for(m_st);
      end else if (ev[2]) begin
         if (m_st == 1)      begin m_hs = 1; m_st = 2; m_ev = int'(cur_min); end
         else if (m_st == 2) begin m_ms = 1; m_st = 0; end
         else if (m_st == 3) begin astb = 1; fld = 2'b01; m_st = 4; m_ev = int'(alm_min); end
         else if (m_st == 4) begin astb = 1; fld = 2'b10; m_st = 0; end
      end else if (ev[1] && m_st != 0) begin
         lim = (m_st == 1 || m_st == 3) ? 23 : 59;
         m_ev = (m_ev >= lim) ? 0 : m_ev + 1;
         inc_done = 1;
      end
      m_setx = (m_hs || m_ms || astb) ? old_ev : m_ev;
      if (astb)           m_as = {1'b1, fld};
      else if (m_st == 3) m_as = 3'b001;
      else if (m_st == 4) m_as = 3'b010;
      else                m_as = 3'b000;
      if (m_st != old_st || inc_done || m_st == 0) m_blink = 0;
      else if (tick_1s)                            m_blink = !m_blink;
      r = m_ring; f = m_fired; c = m_cnt;
      if (m_ring) begin
         if (m_cnt == 0)   r = 0;
         else if (tick_1s) c = m_cnt - 1;
      end
      if (ev != 3'b000 || !alarm_en) r = 0;
      if (cur_min != alm_min) f = 0;
      if (tick_1s && old_st <= 2 && alarm_en && !m_fired &&
          cur_hour == alm_hour && cur_min == alm_min) begin
         r = 1; f = 1; c = RS;
      end
      m_ring = r; m_fired = f; m_cnt = c;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   function automatic logic [15:0] dut_vec();
      return {mode, set_x, hour_set, min_set, alarm_set, blink, ring};
   endfunction

   function automatic logic [15:0] exp_vec();
      return {3'(m_st), 6'(m_setx), m_hs, m_ms, m_as, m_blink, m_ring};
   endfunction

   // Per-cycle comparison and strobe capture
   int         hs_cnt = 0, ms_cnt = 0, as_cnt = 0;
   logic [5:0] hs_x = '0, ms_x = '0, as_x = '0;
   logic [1:0] as_fld = '0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("outs", 32'(dut_vec()), 32'(exp_vec()));
         if (hour_set)     begin hs_cnt++; hs_x = set_x; end
         if (min_set)      begin ms_cnt++; ms_x = set_x; end
         if (alarm_set[2]) begin as_cnt++; as_x = set_x; as_fld = alarm_set[1:0]; end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit [2:0] k);
      @(negedge clk);
      {key_ok, key_inc, key_mode} = k;
      idle(3);
      {key_ok, key_inc, key_mode} = 3'b000;
      idle(5);
   endtask

   task automatic tick_pulse();
      @(negedge clk);
      tick_1s = 1'b1;
      @(negedge clk);
      tick_1s = 1'b0;
   endtask

   int c0;

   initial begin
      idle(3);
      rst_n = 1'b1;
      idle(1);
      check("rst_state", 32'(dut_vec()), 32'h0);

      // Reset mid-edit
      cur_min = 6'd17;
      press(3'b001);
      press(3'b001);
      check("setm_mode", 32'(mode), 32'd2);
      check("setm_x", 32'(set_x), 32'd17);
      c0 = hs_cnt + ms_cnt + as_cnt;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("rst_async", 32'(dut_vec()), 32'h0);
      #2 rst_n = 1'b1;
      idle(6);
      check("rst_nostb", 32'(hs_cnt + ms_cnt + as_cnt - c0), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);

      // Time set with hour and minute wrap
      cur_hour = 6'd22; cur_min = 6'd58;
      press(3'b001);
      press(3'b010);
      press(3'b010);
      c0 = hs_cnt;
      press(3'b100);
      check("hs_cnt", 32'(hs_cnt - c0), 32'd1);
      check("hs_x", 32'(hs_x), 32'd0);
      check("hs_mode", 32'(mode), 32'd2);
      press(3'b010); press(3'b010); press(3'b010);
      c0 = ms_cnt;
      press(3'b100);
      check("ms_cnt", 32'(ms_cnt - c0), 32'd1);
      check("ms_x", 32'(ms_x), 32'd1);
      check("ms_mode", 32'(mode), 32'd0);

      // Alarm set
      alm_hour = 6'd6; alm_min = 6'd45;
      press(3'b001); press(3'b001); press(3'b001);
      check("almh_field", 32'(alarm_set), 32'b001);
      check("almh_mode", 32'(mode), 32'd3);
      press(3'b010);
      c0 = as_cnt;
      press(3'b100);
      check("as_cnt", 32'(as_cnt - c0), 32'd1);
      check("as_x", 32'(as_x), 32'd7);
      check("as_fld", 32'(as_fld), 32'b01);
      check("almm_field", 32'(alarm_set), 32'b010);
      press(3'b001);
      check("back_run", 32'(mode), 32'd0);

      // Ring, countdown, no re-ring in same minute, re-arm, silence
      alarm_en = 1'b1;
      cur_hour = 6'd7; cur_min = 6'd30; alm_hour = 6'd7; alm_min = 6'd30;
      idle(2);
      tick_pulse();
      check("ring_rise", 32'(ring), 32'd1);
      tick_pulse(); tick_pulse(); tick_pulse();
      check("ring_last", 32'(ring), 32'd1);
      idle(1);
      check("ring_end", 32'(ring), 32'd0);
      tick_pulse();
      check("ring_once", 32'(ring), 32'd0);
      cur_min = 6'd31;
      idle(2);
      alm_min = 6'd31;
      tick_pulse();
      check("ring_rearm", 32'(ring), 32'd1);
      press(3'b100);
      check("ring_silence", 32'(ring), 32'd0);
      check("silence_mode", 32'(mode), 32'd0);

      // mode and inc together from RUN
      cur_hour = 6'd9; cur_min = 6'd5;
      press(3'b011);
      check("prio_mode", 32'(mode), 32'd1);
      check("prio_x", 32'(set_x), 32'd9);

      // Held inc key: single event at SYNC_STAGES+1 cycles
      @(negedge clk);
      key_inc = 1'b1;
      idle(SS);
      check("hold_pre", 32'(set_x), 32'd9);
      idle(1);
      check("hold_lat", 32'(set_x), 32'd10);
      idle(97);
      key_inc = 1'b0;
      idle(5);
      check("hold_once", 32'(set_x), 32'd10);
      press(3'b001); press(3'b001); press(3'b001); press(3'b001);
      check("hold_run", 32'(mode), 32'd0);

      // Random phase, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) key_mode = ~key_mode;
         if ($urandom_range(0, 4) == 0) key_inc  = ~key_inc;
         if ($urandom_range(0, 6) == 0) key_ok   = ~key_ok;
         tick_1s = ($urandom_range(0, 7) == 0);
         if (i % 64 == 0) begin
            alarm_en = ($urandom_range(0, 15) != 0);
            alm_hour = 6'd7;
            alm_min  = 6'($urandom_range(30, 31));
            if ($urandom_range(0, 3) == 0) begin
               cur_hour = 6'($urandom_range(0, 23));
               cur_min  = 6'($urandom_range(0, 59));
            end else begin
               cur_hour = 6'($urandom_range(6, 8));
               cur_min  = 6'($urandom_range(29, 32));
            end
         end
      end
      {key_ok, key_inc, key_mode} = 3'b000;
      tick_1s = 1'b0;
      idle(8);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
